// File: rtl/apb4_pkg.sv
// Shared types for the APB4 memory completer: FSM states, error causes
// and the strobe-width helper used to size byte lanes.
package apb4_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_ALIGN,
    ERR_RANGE,
    ERR_RO,
    ERR_PRIV
  } err_cause_e;

  localparam int MAX_WAIT_STATES = 15;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb4_bytemem.sv
// Word-organised storage with per-byte write enables; synchronous write,
// asynchronous read. Contents are deliberately not reset.
module apb4_bytemem
  import apb4_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [AW-1:0]           raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int STRB_W = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 completer in front of a byte-writable word memory, with alignment,
// range, read-only and privilege error responses plus counted wait states.
module apb4_mem_slave
  import apb4_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0,
  parameter int RO_WORDS    = 0,
  parameter int PRIV_ONLY   = 0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int STRB_W = strb_width(DATA_WIDTH);
  localparam int LSB    = $clog2(STRB_W);
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);
  localparam logic [31:0] DEPTH_U    = 32'(MEM_DEPTH);
  localparam logic [31:0] RO_WORDS_U = 32'(RO_WORDS);
  localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_STATES);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  err_cause_e            err_q, err_d;
  logic [MEM_AW-1:0]     idx_q, idx_d;
  logic                  pwrite_q, pwrite_d;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           word_idx_u;
  err_cause_e            setup_cause;
  logic [MEM_AW-1:0]     mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_we;
  logic                  unused_prot;

  assign word_idx    = paddr >> LSB;
  assign word_idx_u  = 32'(word_idx);
  assign unused_prot = ^pprot[2:1];

  // Causes are prioritised so the registered code names the first failing check.
  always_comb begin
    setup_cause = ERR_NONE;
    if ((paddr & ALIGN_MASK) != '0) begin
      setup_cause = ERR_ALIGN;
    end else if (word_idx_u >= DEPTH_U) begin
      setup_cause = ERR_RANGE;
    end else if (pwrite && (word_idx_u < RO_WORDS_U)) begin
      setup_cause = ERR_RO;
    end else if ((PRIV_ONLY != 0) && !pprot[0]) begin
      setup_cause = ERR_PRIV;
    end
  end

  assign mem_raddr = (state_q == IDLE) ? word_idx[MEM_AW-1:0] : idx_q;
  assign mem_we    = (state_q == ACCESS) && psel && penable && (cnt_q == '0)
                     && (err_q == ERR_NONE) && pwrite_q;

  apb4_bytemem #(
    .DEPTH      (MEM_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (MEM_AW)
  ) u_mem (
    .clk   (pclk),
    .we    (mem_we),
    .waddr (idx_q),
    .wdata (pwdata),
    .wstrb (pstrb),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prdata_d = prdata_q;
    err_d    = err_q;
    idx_d    = idx_q;
    pwrite_d = pwrite_q;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d  = ACCESS;
          cnt_d    = WAIT_LOAD;
          err_d    = setup_cause;
          idx_d    = word_idx[MEM_AW-1:0];
          pwrite_d = pwrite;
          prdata_d = ((setup_cause != ERR_NONE) || pwrite) ? '0 : mem_rdata;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else begin
          prdata_d = ((err_q != ERR_NONE) || pwrite_q) ? '0 : mem_rdata;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 4'd1;
          end else if (penable) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prdata_q <= '0;
      err_q    <= ERR_NONE;
      idx_q    <= '0;
      pwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prdata_q <= prdata_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
      pwrite_q <= pwrite_d;
    end
  end

  // An access phase seen from IDLE is answered at once with an error.
  assign pready  = (state_q == ACCESS) ? (cnt_q == '0) : (psel && penable);
  assign pslverr = (state_q == ACCESS) ? ((cnt_q == '0) && (err_q != ERR_NONE))
                                       : (psel && penable);
  assign prdata  = prdata_q;

endmodule
